// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, FSM state type and width
// Shared by the ALU controller, alu_comb and alu_iter so every block
// decodes the same 4-bit operation codes.
package alu_pkg;

  // Operand/result width; the shift-amount field below assumes 32.
  localparam int DATA_WIDTH = 32;
  localparam int SHAMT_W    = 5;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [3:0] OP_SLT = 4'b1100;
  localparam logic [3:0] OP_BLT = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // One bit of an iterative shift; SRA replicates the sign bit.
  function automatic logic [DATA_WIDTH-1:0] shift_step(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] value
  );
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {value[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, value[DATA_WIDTH-1:1]};
      OP_SRA:  r = {value[DATA_WIDTH-1], value[DATA_WIDTH-1:1]};
      default: r = value;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle evaluation of all non-shift ALU codes
// Ports:
//   operation  in   4-bit operation code
//   src_a      in   first operand
//   src_b      in   second operand
//   result     out  result; branch/compare codes return the flag in bit 0
// Shift and undefined codes return 0; shifts are handled iteratively by alu_iter.
module alu_comb #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic [DATA_WIDTH-1:0] result
);
  import alu_pkg::*;

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic                  eq;
  logic                  lt_s;

  always_comb begin
    sum  = src_a + src_b;
    diff = src_a - src_b;
    eq   = (src_a == src_b);
    lt_s = ($signed(src_a) < $signed(src_b));

    result = '0;
    case (operation)
      OP_AND:  result = src_a & src_b;
      OP_OR:   result = src_a | src_b;
      OP_ADD:  result = sum;
      OP_XOR:  result = src_a ^ src_b;
      OP_SUB:  result = diff;
      OP_BEQ:  result = {{(DATA_WIDTH-1){1'b0}}, eq};
      OP_BNE:  result = {{(DATA_WIDTH-1){1'b0}}, ~eq};
      OP_BGE:  result = {{(DATA_WIDTH-1){1'b0}}, ~lt_s};
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      OP_BLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - ALU with valid/ready handshake and one-bit-per-cycle shifter
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   in_valid     in   request present
//   in_ready     out  high only in IDLE
//   operation    in   4-bit operation code
//   src_a        in   first operand
//   src_b        in   second operand; bits [4:0] are the shift amount
//   out_valid    out  high only in DONE
//   out_ready    in   consumer accepts the result
//   alu_result   out  last completed result, held until the next completion
module alu_iter #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result
);
  import alu_pkg::*;

  state_e                state_q,  state_d;
  logic [SHAMT_W-1:0]    count_q,  count_d;
  logic [3:0]            op_q,     op_d;
  logic [DATA_WIDTH-1:0] work_q,   work_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic [DATA_WIDTH-1:0] comb_result;
  logic [DATA_WIDTH-1:0] shifted;
  logic [SHAMT_W-1:0]    shamt_in;
  logic                  accept;
  logic                  start_shift;

  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_alu_comb (
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .result    (comb_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      op_q     <= OP_AND;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    shamt_in    = src_b[SHAMT_W-1:0];
    accept      = in_valid && (state_q == ST_IDLE);
    start_shift = is_shift_op(operation) && (shamt_in != '0);
    shifted     = shift_step(op_q, work_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = start_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (count_q == SHAMT_W'(1)) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per SHIFT cycle.
  always_comb begin
    count_d  = count_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = operation;
          work_d  = src_a;
          count_d = shamt_in;
          // A shift by n>0 leaves the previous result visible until it completes.
          if (!is_shift_op(operation)) begin
            result_d = comb_result;
          end else if (!start_shift) begin
            result_d = src_a;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = shifted;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_d = shifted;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_DONE);
    alu_result = result_q;
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - scoreboard testbench for alu_iter
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;

  alu_iter #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    time         t_obs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b & 32'd31);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0111: return 32'($signed(a) >>> sh);
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      4'b1001: return (a != b) ? 32'd1 : 32'd0;
      4'b1010: return a - b;
      4'b1011: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_shift_cycles(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0100 || op == 4'b0101 || op == 4'b0111) return int'(b & 32'd31);
    return 0;
  endfunction

  // Advance to the next falling edge and drive background traffic.
  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    operation = 4'($urandom);
    src_a     = $urandom;
    src_b     = $urandom;
    in_valid  = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  // Called at a falling edge; returns one falling edge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   guard;
    exp_t e;
    guard = 0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", guard);
      return;
    end
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    e.res     = ref_result(op, a, b);
    e.t_obs   = $time + 10 + 10 * ref_shift_cycles(op, b);
    sb.push_back(e);
    tick();
  endtask

  // Monitor: pops an expectation whenever a new result is presented.
  initial begin : monitor
    logic prev_v;
    logic have;
    exp_t cur;
    prev_v = 1'b0;
    have   = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && in_ready) begin
        checks++;
        errors++;
        $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 at %0t", $time);
      end
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected no out_valid at %0t", alu_result, $time);
          have = 1'b0;
        end else begin
          cur  = sb.pop_front();
          have = 1'b1;
          chk("result", alu_result, cur.res);
          checks++;
          if ($time != cur.t_obs) begin
            errors++;
            $display("FAIL latency: out_valid seen at %0t expected %0t", $time, cur.t_obs);
          end
        end
      end else if (out_valid && have) begin
        chk("result_hold", alu_result, cur.res);
      end
      prev_v = out_valid;
    end
  end

  initial begin : driver
    int guard;
    reset     = 1'b1;
    in_valid  = 1'b0;
    operation = 4'b0000;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", alu_result, 32'd0);

    // ADD wrap, one-cycle latency, back-to-back accept two cycles apart.
    rdy_mode = 0;
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("add_busy_in_ready", 32'(in_ready), 32'd0);
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_value", alu_result, 32'h0000_0001);
    tick();
    chk("add_next_ready", 32'(in_ready), 32'd1);

    // SRA by 4 (upper bits of src_b ignored): five busy cycles.
    issue(4'b0111, 32'h8000_0000, 32'h0000_0024);
    for (int i = 0; i < 5; i++) begin
      chk("sra_in_ready", 32'(in_ready), 32'd0);
      chk("sra_out_valid", 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    chk("sra_value", alu_result, 32'hF800_0000);
    tick();

    // Branch / compare flags.
    issue(4'b1110, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1011, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1001, 32'd5, 32'd5);
    issue(4'b1100, 32'd3, 32'd3);

    // Backpressure: result held while out_ready is low and inputs churn.
    rdy_mode = 2;
    issue(4'b1010, 32'd5, 32'd7);
    for (int i = 0; i < 3; i++) begin
      src_a = ~src_a;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_value", alu_result, 32'hFFFF_FFFE);
      if (i < 2) tick();
    end
    rdy_mode = 0;
    tick();

    // Reset in the third SHIFT cycle of SLL by 31 aborts with no result.
    issue(4'b0100, 32'h1234_5677, 32'd31);
    chk("abort_sh1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("abort_sh2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("abort_sh3_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", alu_result, 32'd0);
    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("and_after_abort", alu_result, 32'hF000_F000);

    // Reset wins over a handshake in the same cycle.
    tick();
    issue(4'b0010, 32'd1, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_prio_result", alu_result, 32'd0);
    chk("rst_prio_in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic with random backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 120; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      issue(op, a, b);
    end

    // Drain outstanding results.
    rdy_mode = 0;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  request present.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: operation  input  4  ALU operation code from the ALU controller.
REQ-007 Port: src_a  input  DATA_WIDTH  first operand.
REQ-008 Port: src_b  input  DATA_WIDTH  second operand or shift amount.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: alu_result  output  DATA_WIDTH  result; for branch codes, bit 0 is the taken flag and the upper bits are 0.

Function
REQ-012 Operation codes: 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL; 0111 SRA; 1000 BEQ; 1001 BNE; 1010 SUB; 1011 BGE (signed); 1100 SLT (signed); 1110 BLT (signed).
REQ-013 Undefined codes (0110, 1101, 1111): alu_result = 0, with normal non-shift latency.
REQ-014 Arithmetic: ADD/SUB wrap modulo 2^32; SLT yields 1 or 0 in bit 0.
REQ-015 Shift amount: src_b[4:0]; upper bits of src_b are ignored.
REQ-016 FSM states: IDLE, SHIFT, DONE.
REQ-017 in_ready: 1 only in IDLE.
REQ-018 out_valid: 1 only in DONE.
REQ-019 Accept: occurs on in_valid && in_ready; operation, src_a and the shift amount are captured in internal registers at that edge.
REQ-020 IDLE transitions: accept with a non-shift code, or a shift code with amount 0 -> DONE; accept with a shift code and amount n>0 -> SHIFT with count = n.
REQ-021 SHIFT: each cycle shifts the working register by one bit (SLL fill 0, SRL fill 0, SRA fill the sign bit) and decrements count; when count reaches 1, the next state is DONE.
REQ-022 Latency: accept at edge T -> out_valid high after edge T+1 (non-shift) or edge T+1+n (shift by n>0).
REQ-023 DONE: alu_result and out_valid are held stable until out_valid && out_ready; that edge returns the block to IDLE.
REQ-024 No same-cycle accept in DONE; the earliest next accept is the edge after the handshake, giving a maximum throughput of one operation per 2 cycles.
REQ-025 Input changes while not in IDLE have no effect on the in-flight operation.
REQ-026 alu_result in IDLE and SHIFT: holds the last completed result (0 after reset).

Reset
REQ-027 reset high at a clock edge -> state IDLE, count 0, alu_result 0, out_valid 0, in_ready 1 from the following cycle.
REQ-028 reset takes priority over any handshake in the same cycle.
REQ-029 reset during SHIFT or DONE aborts the operation and discards its result, with no out_valid pulse.

Structure
REQ-030 Shared package alu_pkg: the 4-bit operation code constants (REQ-012), the FSM state enum, and DATA_WIDTH.
REQ-031 The ALU controller and alu_iter import the same alu_pkg codes.
REQ-032 Single sub-module alu_comb: purely combinational, evaluating all non-shift codes; alu_iter instantiates it once and registers its output on accept.

Verification
REQ-033 Reset: reset held 2 cycles then released -> in_ready=1, out_valid=0, alu_result=0.
REQ-034 ADD: 0010 with A=0xFFFFFFFF, B=0x00000002, out_ready=1 -> out_valid exactly 1 cycle after accept, alu_result=0x00000001; next accept is possible 2 cycles after the first.
REQ-035 SRA: 0111 with A=0x80000000, B=0x00000024 (amount 4) -> out_valid 5 cycles after accept, alu_result=0xF8000000; in_ready=0 for those 5 cycles.
REQ-036 Branch/compare: BLT (1110) with A=0xFFFFFFFF, B=1 -> alu_result=1; BGE (1011) with the same operands -> 0; BNE (1001) with A=B=5 -> 0; SLT (1100) with A=3, B=3 -> 0.
REQ-037 Backpressure: SUB (1010) with A=5, B=7 and out_ready=0 for 3 cycles -> alu_result=0xFFFFFFFE held stable with out_valid=1 throughout; src_a is changed meanwhile without any effect on alu_result.
REQ-038 Abort: SLL (0100) with amount 31 and reset asserted in the 3rd SHIFT cycle -> no out_valid pulse, IDLE with alu_result=0 afterwards; an AND (0000) with A=0xF0F0F0F0, B=0xFF00FF00 issued immediately afterwards -> 0xF000F000.
